exec_alu_stage: RTL and testbench

Execute stage of the CPU pipeline, sitting directly upstream of the memory/write-back stage. It accepts decoded operations, computes ALU results and load/store addresses, and runs signed and unsigned division/remainder iteratively. Results go into one registered output slot that drives both the write-back state and the data-memory request, so `mem_data_in` reaches write-back one cycle later.

---
 rtl/exec_alu_stage_pkg.sv | 32 +++
 rtl/exec_alu_stage_if.sv | 35 +++
 rtl/exec_alu_stage_div.sv | 91 +++++++++
 rtl/exec_alu_stage.sv | 146 ++++++++++++++
 tb/tb_exec_alu_stage.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/exec_alu_stage_pkg.sv
// Shared types for the execute stage: op codes, the output slot record and FSM states.
package exec_stage_pkg;

  localparam int XLEN     = 32;
  localparam int REG_BITS = 5;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_LOAD, OP_STORE
  } exec_op_t;

  // Same layout as the record the write-back stage shifts.
  typedef struct packed {
    logic [XLEN-1:0]     result;
    logic [REG_BITS-1:0] rd;
    logic                wb_en;
    logic                mem_rd;
    logic                mem_wr;
    logic [XLEN-1:0]     store_data;
  } exec_result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV_RUN,
    ST_DIV_FIN
  } exec_state_t;

  function automatic logic is_div_op(exec_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/exec_alu_stage_if.sv
// Decoded-op input handshake and registered result slot of the execute stage.
interface exec_alu_stage_if;
  import exec_stage_pkg::*;

  logic                in_valid;
  logic                in_ready;
  exec_op_t            in_op;
  logic                in_use_imm;
  logic [XLEN-1:0]     in_rs1;
  logic [XLEN-1:0]     in_rs2;
  logic [XLEN-1:0]     in_imm;
  logic [REG_BITS-1:0] in_rd;

  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_result;
  logic [REG_BITS-1:0] out_rd;
  logic                out_wb_en;
  logic                out_mem_rd;
  logic                out_mem_wr;
  logic [XLEN-1:0]     out_store_data;

  modport slave (
    input  in_valid, in_op, in_use_imm, in_rs1, in_rs2, in_imm, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wb_en, out_mem_rd,
           out_mem_wr, out_store_data
  );

  modport master (
    output in_valid, in_op, in_use_imm, in_rs1, in_rs2, in_imm, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wb_en, out_mem_rd,
           out_mem_wr, out_store_data
  );

endinterface

// File: rtl/exec_alu_stage_div.sv
// Restoring divider: one quotient bit per cycle on magnitudes, signs and
// divide-by-zero fixed up on the registered result.
module iter_divider
  import exec_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  logic            busy_q, busy_d;
  logic [4:0]      count_q, count_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, dvd_q, dvd_d;
  logic            zero_q, zero_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic [XLEN:0]   shifted, diff;
  logic            a_neg, b_neg;

  always_comb begin
    a_neg   = signed_i && dividend_i[XLEN-1];
    b_neg   = signed_i && divisor_i[XLEN-1];
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    busy_d  = busy_q;
    count_d = count_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    zero_d  = zero_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    if (abort_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d  = 1'b1;
      count_d = 5'd31;
      quo_d   = a_neg ? -dividend_i : dividend_i;
      rem_d   = '0;
      dvs_d   = b_neg ? -divisor_i : divisor_i;
      dvd_d   = dividend_i;
      zero_d  = (divisor_i == '0);
      qneg_d  = a_neg ^ b_neg;
      rneg_d  = a_neg;
    end else if (busy_q) begin
      // Dividend bits shift out of quo_q while quotient bits shift in.
      quo_d = {quo_q[XLEN-2:0], !diff[XLEN]};
      rem_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      if (count_q == 5'd0) busy_d = 1'b0;
      else                 count_d = count_q - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      count_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      zero_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      zero_q  <= zero_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = busy_q && (count_q == 5'd0);
  // MIN/-1 needs no special case: negating 0x80000000 yields 0x80000000.
  assign quotient_o  = zero_q ? '1 : (qneg_q ? -quo_q : quo_q);
  assign remainder_o = zero_q ? dvd_q : (rneg_q ? -rem_q : rem_q);

endmodule

// File: rtl/exec_alu_stage.sv
// Execute stage: single-cycle ALU/address ops, iterative division, and one
// registered output slot feeding write-back and the data-memory request.
//   state      | meaning
//   ST_IDLE    | accepting ops; single-cycle results written to the slot
//   ST_DIV_RUN | divider iterating, counter 31 -> 0
//   ST_DIV_FIN | signed result ready, waiting for the slot to be free
module exec_alu_stage
  import exec_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  exec_alu_stage_if.slave  bus
);

  exec_state_t         state_q, state_d;
  exec_result_t        slot_q, slot_d, alu_res, div_res;
  logic                valid_q, valid_d;
  logic [REG_BITS-1:0] pend_rd_q, pend_rd_d;
  logic                pend_rem_q, pend_rem_d;
  logic [XLEN-1:0]     op_b, alu_val, quotient, remainder;
  logic [4:0]          shamt;
  logic                in_ready, accept, div_start, div_busy, div_done, div_signed;

  assign in_ready   = (state_q == ST_IDLE) && (!valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready && !flush_i;
  assign op_b       = bus.in_use_imm ? bus.in_imm : bus.in_rs2;
  assign shamt      = op_b[4:0];
  assign div_signed = (bus.in_op == OP_DIV) || (bus.in_op == OP_REM);

  always_comb begin
    alu_val = '0;
    unique case (bus.in_op)
      OP_ADD:   alu_val = bus.in_rs1 + op_b;
      OP_SUB:   alu_val = bus.in_rs1 - op_b;
      OP_AND:   alu_val = bus.in_rs1 & op_b;
      OP_OR:    alu_val = bus.in_rs1 | op_b;
      OP_XOR:   alu_val = bus.in_rs1 ^ op_b;
      OP_SLL:   alu_val = bus.in_rs1 << shamt;
      OP_SRL:   alu_val = bus.in_rs1 >> shamt;
      OP_SRA:   alu_val = $unsigned($signed(bus.in_rs1) >>> shamt);
      OP_SLT:   alu_val = {31'd0, $signed(bus.in_rs1) < $signed(op_b)};
      OP_SLTU:  alu_val = {31'd0, bus.in_rs1 < op_b};
      OP_LOAD,
      OP_STORE: alu_val = bus.in_rs1 + bus.in_imm;
      default:  alu_val = '0;
    endcase
    alu_res.result     = alu_val;
    alu_res.rd         = bus.in_rd;
    alu_res.wb_en      = (bus.in_op != OP_STORE) && (bus.in_rd != '0);
    alu_res.mem_rd     = (bus.in_op == OP_LOAD);
    alu_res.mem_wr     = (bus.in_op == OP_STORE);
    alu_res.store_data = (bus.in_op == OP_STORE) ? bus.in_rs2 : '0;
  end

  always_comb begin
    div_res.result     = pend_rem_q ? remainder : quotient;
    div_res.rd         = pend_rd_q;
    div_res.wb_en      = (pend_rd_q != '0);
    div_res.mem_rd     = 1'b0;
    div_res.mem_wr     = 1'b0;
    div_res.store_data = '0;
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    valid_d    = valid_q;
    pend_rd_d  = pend_rd_q;
    pend_rem_d = pend_rem_q;
    div_start  = 1'b0;
    if (valid_q && bus.out_ready) valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_div_op(bus.in_op)) begin
            state_d    = ST_DIV_RUN;
            div_start  = 1'b1;
            pend_rd_d  = bus.in_rd;
            pend_rem_d = (bus.in_op == OP_REM) || (bus.in_op == OP_REMU);
          end else begin
            slot_d  = alu_res;
            valid_d = 1'b1;
          end
        end
      end
      ST_DIV_RUN: if (div_done) state_d = ST_DIV_FIN;
      ST_DIV_FIN: begin
        if (!valid_q || bus.out_ready) begin
          slot_d  = div_res;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      valid_d = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      valid_q    <= 1'b0;
      pend_rd_q  <= '0;
      pend_rem_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      valid_q    <= valid_d;
      pend_rd_q  <= pend_rd_d;
      pend_rem_q <= pend_rem_d;
    end
  end

  iter_divider u_div (
    .clk         (clk),
    .reset       (reset),
    .start_i     (div_start),
    .abort_i     (flush_i),
    .signed_i    (div_signed),
    .dividend_i  (bus.in_rs1),
    .divisor_i   (op_b),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  // busy is implied by state; kept on the divider port for other users.
  logic unused_busy;
  assign unused_busy = div_busy;

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = valid_q;
  assign bus.out_result     = slot_q.result;
  assign bus.out_rd         = slot_q.rd;
  assign bus.out_wb_en      = slot_q.wb_en;
  assign bus.out_mem_rd     = valid_q && slot_q.mem_rd;
  assign bus.out_mem_wr     = valid_q && slot_q.mem_wr;
  assign bus.out_store_data = slot_q.store_data;

endmodule

// File: tb/tb_exec_alu_stage.sv
// Directed bench for exec_alu_stage: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed.
module tb_exec_alu_stage;
  import exec_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   ntests = 0;
  int   nfail  = 0;
  int   ld_cnt = 0;
  logic bad;

  always #5 clk = ~clk;

  exec_alu_stage_if bus ();

  exec_alu_stage dut (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .bus     (bus)
  );

  always @(posedge clk)
    if (bus.out_valid && bus.out_ready && bus.out_mem_rd) ld_cnt <= ld_cnt + 1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(exec_op_t op, logic [31:0] rs1, logic [31:0] rs2,
                       logic [31:0] imm, logic use_imm, logic [4:0] rd);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_imm     = imm;
    bus.in_use_imm = use_imm;
    bus.in_rd      = rd;
  endtask

  task automatic run_div(string tag, exec_op_t op, logic [31:0] a, logic [31:0] b,
                         logic [4:0] rd, logic [31:0] exp);
    logic busy_bad;
    busy_bad = 1'b0;
    drive(op, a, b, 32'h0, 1'b0, rd);
    for (int k = 1; k <= 33; k++) begin
      cyc();
      if (k == 1) bus.in_valid = 1'b0;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) busy_bad = 1'b1;
    end
    check({tag, "_busy"}, busy_bad, 0);
    cyc();
    check({tag, "_valid"}, bus.out_valid, 1);
    check(tag, bus.out_result, exp);
    check({tag, "_rd"}, bus.out_rd, rd);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_op      = OP_ADD;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_imm     = '0;
    bus.in_use_imm = 1'b0;
    bus.in_rd      = '0;
    bus.out_ready  = 1'b1;
    flush          = 1'b0;
    reset          = 1'b1;
    repeat (3) cyc();
    check("rst_valid", bus.out_valid, 0);
    check("rst_result", bus.out_result, 0);
    check("rst_rd", bus.out_rd, 0);
    check("rst_wb_en", bus.out_wb_en, 0);
    check("rst_in_ready", bus.in_ready, 1);
    reset = 1'b0;
    cyc();

    // Back-to-back single-cycle ops
    drive(OP_ADD, 32'd5, 32'h0, 32'hFFFF_FFF9, 1'b1, 5'd3);
    cyc();
    check("add_valid", bus.out_valid, 1);
    check("add_result", bus.out_result, 32'hFFFF_FFFE);
    check("add_wb_en", bus.out_wb_en, 1);
    check("add_rd", bus.out_rd, 3);
    drive(OP_SRA, 32'h8000_0000, 32'h0, 32'd4, 1'b1, 5'd7);
    cyc();
    check("sra_valid", bus.out_valid, 1);
    check("sra_result", bus.out_result, 32'hF800_0000);
    drive(OP_SUB, 32'd3, 32'd5, 32'd100, 1'b0, 5'd1);
    cyc();
    check("sub_result", bus.out_result, 32'hFFFF_FFFE);
    drive(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 5'd2);
    cyc();
    check("slt_result", bus.out_result, 1);
    drive(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 5'd2);
    cyc();
    check("sltu_result", bus.out_result, 0);
    drive(OP_SLL, 32'd1, 32'd33, 32'h0, 1'b0, 5'd2);
    cyc();
    check("sll_result", bus.out_result, 2);
    drive(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0, 1'b0, 5'd0);
    cyc();
    check("xor_result", bus.out_result, 32'h0000_FF00);
    check("xor_rd0_wb_en", bus.out_wb_en, 0);
    drive(OP_STORE, 32'h1000, 32'hDEAD_BEEF, 32'd8, 1'b0, 5'd9);
    cyc();
    check("st_result", bus.out_result, 32'h1008);
    check("st_mem_wr", bus.out_mem_wr, 1);
    check("st_mem_rd", bus.out_mem_rd, 0);
    check("st_wb_en", bus.out_wb_en, 0);
    check("st_data", bus.out_store_data, 32'hDEAD_BEEF);
    bus.in_valid = 1'b0;
    cyc();

    // Division, including special cases; all at fixed latency
    run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD);
    run_div("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
    run_div("divu_9_0", OP_DIVU, 32'd9, 32'd0, 5'd7, 32'hFFFF_FFFF);
    run_div("remu_9_0", OP_REMU, 32'd9, 32'd0, 5'd7, 32'd9);
    run_div("rem_min_m1", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0);
    run_div("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000);
    run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14);
    run_div("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1);
    cyc();

    // Back-pressure on a LOAD with the next op queued
    bus.out_ready = 1'b0;
    drive(OP_LOAD, 32'h200, 32'h0, 32'h10, 1'b1, 5'd4);
    cyc();
    check("ld_result", bus.out_result, 32'h210);
    check("ld_mem_rd", bus.out_mem_rd, 1);
    drive(OP_ADD, 32'd1, 32'h0, 32'd1, 1'b1, 5'd5);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h210 || bus.out_mem_rd !== 1'b1 ||
          bus.out_rd !== 5'd4 || bus.in_ready !== 1'b0) bad = 1'b1;
      if (i < 4) cyc();
    end
    check("ld_stall_stable", bad, 0);
    bus.out_ready = 1'b1;
    #1;
    check("ld_release_ready", bus.in_ready, 1);
    cyc();
    check("refill_valid", bus.out_valid, 1);
    check("refill_result", bus.out_result, 2);
    check("refill_rd", bus.out_rd, 5);
    check("refill_mem_rd", bus.out_mem_rd, 0);
    check("ld_consumes", ld_cnt, 1);
    bus.in_valid = 1'b0;
    cyc();
    check("drain_valid", bus.out_valid, 0);
    check("ld_consumes_after", ld_cnt, 1);

    // Flush ten cycles into a division
    drive(OP_DIV, 32'd100, 32'd7, 32'h0, 1'b0, 5'd6);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 1) bus.in_valid = 1'b0;
    end
    flush = 1'b1;
    drive(OP_ADD, 32'd1, 32'h0, 32'd1, 1'b1, 5'd5);
    cyc();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_in_ready", bus.in_ready, 1);
    check("flush_valid", bus.out_valid, 0);
    bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (bus.out_valid !== 1'b0) bad = 1'b1;
    end
    check("flush_no_result", bad, 0);

    // Flush wins over a same-cycle accept
    drive(OP_ADD, 32'd1, 32'h0, 32'd1, 1'b1, 5'd8);
    flush = 1'b1;
    #1;
    check("flush_acc_ready", bus.in_ready, 1);
    cyc();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_acc_dropped", bus.out_valid, 0);
    cyc();
    check("flush_acc_dropped2", bus.out_valid, 0);

    // Reset in the middle of a division clears the slot contents
    drive(OP_ADD, 32'h11, 32'h0, 32'h22, 1'b1, 5'd9);
    cyc();
    check("pre_rst_result", bus.out_result, 32'h33);
    drive(OP_DIV, 32'd100, 32'd7, 32'h0, 1'b0, 5'd10);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 1) bus.in_valid = 1'b0;
    end
    check("mid_div_held_result", bus.out_result, 32'h33);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mrst_valid", bus.out_valid, 0);
    check("mrst_result", bus.out_result, 0);
    check("mrst_rd", bus.out_rd, 0);
    check("mrst_wb_en", bus.out_wb_en, 0);
    check("mrst_store_data", bus.out_store_data, 0);
    check("mrst_in_ready", bus.in_ready, 1);
    bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (bus.out_valid !== 1'b0) bad = 1'b1;
    end
    check("mrst_no_result", bad, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
